// File: rtl/ascon_pack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ascon_pack : shared widths and defaults for the Ascon bus-side blocks |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ascon_pack;
  localparam int AsconWordWidth   = 64;
  localparam int BusWidth         = 32;
  localparam int DefaultFifoDepth = 8;
endpackage
`default_nettype wire

// File: rtl/ascon_word_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ascon_word_fifo : packs 32-bit bus writes into 64-bit Ascon words and |
// | buffers them in a first-word-fall-through FIFO for the core.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ascon_word_fifo
  import ascon_pack::*;
#(
  parameter int  DEPTH      = DefaultFifoDepth,
  localparam int LevelWidth = $clog2(DEPTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      wr_en_i,
  input  logic [BusWidth-1:0]       wr_data_i,
  output logic                      wr_ready_o,
  input  logic                      flush_i,
  input  logic                      pop_i,
  output logic [AsconWordWidth-1:0] data_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic [LevelWidth-1:0]     level_o,
  output logic                      half_valid_o,
  output logic                      overflow_o,
  output logic                      underflow_o
);

  localparam int PtrWidth = $clog2(DEPTH);

  logic [AsconWordWidth-1:0] r_mem [DEPTH];
  logic [PtrWidth-1:0]       r_wr_ptr;
  logic [PtrWidth-1:0]       r_rd_ptr;
  logic [LevelWidth-1:0]     r_level;
  logic [BusWidth-1:0]       r_hi;
  logic                      r_half_valid;
  logic                      r_empty;
  logic                      r_full;
  logic                      r_overflow;
  logic                      r_underflow;

  logic                      w_wr_ready;
  logic                      w_wr_acc;
  logic                      w_push;
  logic                      w_pop;
  logic [LevelWidth-1:0]     w_level_nxt;

  // A lower half may enter a full FIFO only when the head leaves in the same cycle.
  always_comb begin
    w_wr_ready  = !r_half_valid | !r_full | pop_i;
    w_wr_acc    = wr_en_i & w_wr_ready & !flush_i;
    w_push      = w_wr_acc & r_half_valid;
    w_pop       = pop_i & !r_empty & !flush_i;
    w_level_nxt = r_level + LevelWidth'(w_push) - LevelWidth'(w_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_half_valid <= 1'b0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrWidth'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrWidth'(1);
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == LevelWidth'(DEPTH));
      if (w_wr_acc) r_half_valid <= !r_half_valid;
      if (wr_en_i && !w_wr_ready) r_overflow  <= 1'b1;
      if (pop_i && r_empty)       r_underflow <= 1'b1;
    end
  end

  // Holding register and storage carry no reset; validity is tracked separately.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc && !r_half_valid) r_hi <= wr_data_i;
    if (w_push) r_mem[r_wr_ptr] <= {r_hi, wr_data_i};
  end

  assign wr_ready_o   = w_wr_ready;
  assign data_o       = r_empty ? '0 : r_mem[r_rd_ptr];
  assign empty_o      = r_empty;
  assign full_o       = r_full;
  assign level_o      = r_level;
  assign half_valid_o = r_half_valid;
  assign overflow_o   = r_overflow;
  assign underflow_o  = r_underflow;

endmodule
`default_nettype wire
